// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer: FSM states, BCD digit type
// and the clamp helper used when presets are latched.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps from 0 to MAX and raises borrow_out
// so the next more significant digit decrements in the same cycle.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  bcd_t load_value,
  input  logic dec,
  output bcd_t value,
  output logic borrow_out
);

  bcd_t r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_value;
    end else if (dec) begin
      r_value <= (r_value == 4'd0) ? MAX : r_value - 4'd1;
    end
  end

  assign value      = r_value;
  assign borrow_out = dec && (r_value == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// SS.hh countdown timer: 10 ms prescaler, four-digit BCD down-count, IDLE/RUN/PAUSE/EXPIRED FSM.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry instead of halting.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int TICK_W   = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset0,
  input  logic [3:0] preset1,
  input  logic [3:0] preset2,
  input  logic [3:0] preset3,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse,
  output state_t     o_state
);

  state_t            r_state;
  state_t            w_next;
  logic [TICK_W-1:0] r_presc;
  bcd_t [3:0]        r_preset;
  logic              r_running;
  logic              r_expired;
  logic              r_expire_pulse;

  bcd_t [3:0]        w_clamped;
  bcd_t [3:0]        w_digit;
  bcd_t [3:0]        w_dig_value;
  logic [4:0]        w_dec_chain;
  logic              w_presc_end;
  logic              w_tick;
  logic              w_count_nz;
  logic              w_is_one;
  logic              w_expire;
  logic              w_reload;
  logic              w_dig_load;
  logic              w_dec;

  assign w_clamped = {clamp_digit(preset3, TENS_MAX), clamp_digit(preset2, DIGIT_MAX),
                      clamp_digit(preset1, DIGIT_MAX), clamp_digit(preset0, DIGIT_MAX)};

  assign w_count_nz  = (w_digit != 16'h0000);
  assign w_is_one    = (w_digit == 16'h0001);
  assign w_presc_end = (r_presc == TICK_W'(TICK_DIV - 1));
  // A load in the same cycle swallows the tick, so it can never expire the count.
  assign w_tick      = (r_state == RUN) && !load && w_presc_end;
  assign w_expire    = w_tick && w_is_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign w_reload = w_expire;
`else
  assign w_reload = 1'b0;
`endif

  assign w_dig_load     = load || w_reload;
  assign w_dig_value    = load ? w_clamped : r_preset;
  assign w_dec          = w_tick && !w_reload && w_count_nz;
  assign w_dec_chain[0] = w_dec;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    bcd_down_digit #(
      .MAX((gi == 3) ? TENS_MAX : DIGIT_MAX)
    ) u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (w_dig_load),
      .load_value (w_dig_value[gi]),
      .dec        (w_dec_chain[gi]),
      .value      (w_digit[gi]),
      .borrow_out (w_dec_chain[gi+1])
    );
  end

  // A borrow out of the tens-of-seconds digit would mean the count wrapped below 00.00.
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !w_dec_chain[4]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (load) begin
      r_presc <= '0;
    end else if (r_state == RUN) begin
      r_presc <= w_presc_end ? '0 : r_presc + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_preset <= '0;
    end else if (load) begin
      r_preset <= w_clamped;
    end
  end

  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (start && !stop && w_count_nz) w_next = RUN;
        end
        RUN: begin
          if (w_expire) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_next = RUN;
`else
            w_next = EXPIRED;
`endif
          end else if (stop) begin
            w_next = PAUSE;
          end
        end
        EXPIRED: w_next = EXPIRED;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_running      <= 1'b0;
      r_expired      <= 1'b0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_running      <= (w_next == RUN);
      r_expired      <= (w_next == EXPIRED);
      r_expire_pulse <= w_expire;
    end
  end

  assign digit0       = w_digit[0];
  assign digit1       = w_digit[1];
  assign digit2       = w_digit[2];
  assign digit3       = w_digit[3];
  assign running      = r_running;
  assign expired      = r_expired;
  assign expire_pulse = r_expire_pulse;
  assign o_state      = r_state;

endmodule
